// File: rtl/spi_responder_if.sv
// Bus bundle for spi_responder: SPI pins plus the local tx/rx handshake and status strobes.
// The slave modport is the responder's view; master is the driving side (top level or bench).
interface spi_responder_if #(
  parameter int unsigned WIDTH = 12
);
  logic             sclk;
  logic             cs;
  logic             mosi;
  logic             miso;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;
  logic             underrun;
  logic             frame_err;

  modport slave (
    input  sclk, cs, mosi, tx_data, tx_valid,
    output miso, tx_ready, rx_data, rx_valid, busy, underrun, frame_err
  );

  modport master (
    output sclk, cs, mosi, tx_data, tx_valid,
    input  miso, tx_ready, rx_data, rx_valid, busy, underrun, frame_err
  );
endinterface

// File: rtl/spi_responder.sv
// SPI mode-0, LSB-first slave running on the system clock: captures a WIDTH-bit frame on
// MOSI while returning a buffered response word on MISO, with rx/underrun/abort strobes.
module spi_responder #(
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst,
  spi_responder_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Synchronizers and edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_d_q;
  logic                   cs_d_q;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_rise;
  logic                   cs_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_d_q    <= 1'b0;
      cs_d_q      <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_d_q    <= sclk_s;
      cs_d_q      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d_q;
  assign sclk_fall = ~sclk_s & sclk_d_q;
  assign cs_rise   = cs_s & ~cs_d_q;
  assign cs_fall   = ~cs_s & cs_d_q;

  // Frame state, shift registers and transmit buffer
  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CntW-1:0]  cnt_inc;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  // Only the upper WIDTH-1 received bits need storing; the newest bit arrives on mosi_s.
  logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_word;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             underrun_q, underrun_d;
  logic             frame_err_q, frame_err_d;
  logic             direct_load;

  assign cnt_inc = cnt_q + CntW'(1);
  assign rx_word = {mosi_s, rx_shift_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    direct_load = 1'b0;

    case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d    = StShift;
          cnt_d      = '0;
          rx_shift_d = '0;
          if (buf_full_q) begin
            tx_shift_d = buf_q;
            buf_full_d = 1'b0;
          end else if (bus.tx_valid) begin
            // Word offered exactly at frame start bypasses the buffer.
            tx_shift_d  = bus.tx_data;
            direct_load = 1'b1;
          end else begin
            tx_shift_d = '0;
            underrun_d = 1'b1;
          end
        end
      end

      StShift: begin
        // cs release has priority over any sclk edge seen in the same cycle.
        if (cs_rise) begin
          state_d     = StIdle;
          tx_shift_d  = '0;
          frame_err_d = 1'b1;
        end else if (sclk_rise) begin
          rx_shift_d = rx_word[WIDTH-1:1];
          cnt_d      = cnt_inc;
          if (cnt_inc == CntW'(WIDTH)) begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            state_d    = StDone;
          end
        end else if (sclk_fall && (cnt_q != '0) && (cnt_q < CntW'(WIDTH))) begin
          tx_shift_d = tx_shift_q >> 1;
        end
      end

      StDone: begin
        if (cs_rise) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    if (bus.tx_valid && !buf_full_q && !direct_load) begin
      buf_d      = bus.tx_data;
      buf_full_d = 1'b1;
    end
  end

  assign bus.miso      = (state_q != StIdle) & tx_shift_q[0];
  assign bus.busy      = (state_q != StIdle);
  assign bus.tx_ready  = ~buf_full_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.underrun  = underrun_q;
  assign bus.frame_err = frame_err_q;

endmodule
